// File: rtl/bram_pingpong_if.sv
// Load/execute/BRAM-port bundle for the ping-pong buffer controller.
// The master side is the controller; the slave side is the surrounding fabric.
interface bram_pingpong_if #(
  parameter int AW = 8,
  parameter int DW = 256
);
  logic [AW:0]   cfg_len;
  logic          ld_valid;
  logic          ld_ready;
  logic [DW-1:0] ld_data;
  logic          ex_valid;
  logic          ex_ready;
  logic [DW-1:0] ex_data;
  logic          ex_last;
  logic          mem_wr_en;
  logic [AW:0]   mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic [AW:0]   mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic [1:0]    bank_full;

  modport master (
    input  cfg_len, ld_valid, ld_data, ex_ready, mem_rd_data,
    output ld_ready, ex_valid, ex_data, ex_last,
           mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr, bank_full
  );

  modport slave (
    output cfg_len, ld_valid, ld_data, ex_ready, mem_rd_data,
    input  ld_ready, ex_valid, ex_data, ex_last,
           mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr, bank_full
  );
endinterface

// File: rtl/bram_pingpong_ctrl.sv
// Ping-pong controller over one simple-dual-port BRAM: MSB of the address picks the bank,
// load fills one bank while execute streams the other through an output register + skid.
module bram_pingpong_ctrl #(
  parameter int AW = 8,
  parameter int DW = 256
) (
  input logic            clk,
  input logic            rst_n,
  bram_pingpong_if.master bus
);
  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_st_e;
  typedef enum logic [1:0] {EX_IDLE, EX_STREAM, EX_FLUSH} ex_st_e;

  bank_st_e      bank_st_q [2], bank_st_d [2];
  logic [AW:0]   len_q [2], len_d [2];
  logic          ld_bank_q, ld_bank_d, ex_bank_q, ex_bank_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  ex_st_e        ex_st_q, ex_st_d;
  logic          ld_ready_q, ld_ready_d;
  logic          inflight_q, inflight_d, inflight_last_q, inflight_last_d;
  logic          ex_valid_q, ex_valid_d, ex_last_q, ex_last_d;
  logic [DW-1:0] ex_data_q, ex_data_d;
  logic          skid_vld_q, skid_vld_d, skid_last_q, skid_last_d;
  logic [DW-1:0] skid_data_q, skid_data_d;

  logic          hs, first_ld, wr_last, rd_last, pop, slot_free, issue, space_ok;
  logic [AW:0]   eff_len, ld_len_m1, ex_len_m1;
  logic [1:0]    occ_after;
  bank_st_e      nxt_ld_st;

  always_comb begin
    bank_st_d       = bank_st_q;
    len_d           = len_q;
    ld_bank_d       = ld_bank_q;
    ex_bank_d       = ex_bank_q;
    wr_cnt_d        = wr_cnt_q;
    rd_cnt_d        = rd_cnt_q;
    ex_st_d         = ex_st_q;
    ex_valid_d      = ex_valid_q;
    ex_last_d       = ex_last_q;
    ex_data_d       = ex_data_q;
    skid_vld_d      = skid_vld_q;
    skid_last_d     = skid_last_q;
    skid_data_d     = skid_data_q;

    hs        = ld_ready_q & bus.ld_valid;
    first_ld  = (bank_st_q[ld_bank_q] == B_EMPTY);
    eff_len   = (bus.cfg_len == '0) ? (AW+1)'(1) : bus.cfg_len;
    ld_len_m1 = (first_ld ? eff_len : len_q[ld_bank_q]) - (AW+1)'(1);
    ex_len_m1 = len_q[ex_bank_q] - (AW+1)'(1);
    wr_last   = ({1'b0, wr_cnt_q} == ld_len_m1);
    rd_last   = ({1'b0, rd_cnt_q} == ex_len_m1);

    // Issue only if out-reg + skid + in-flight still fits in two slots after this pop.
    pop       = ex_valid_q & bus.ex_ready;
    slot_free = ~ex_valid_q | bus.ex_ready;
    occ_after = {1'b0, ex_valid_q & ~bus.ex_ready} + {1'b0, skid_vld_q};
    space_ok  = (occ_after + {1'b0, inflight_q}) <= 2'd1;
    issue     = space_ok & ((ex_st_q == EX_STREAM) |
                ((ex_st_q == EX_IDLE) & (bank_st_q[ex_bank_q] == B_FULL)));

    if (hs) begin
      wr_cnt_d = wr_cnt_q + AW'(1);
      if (first_ld) begin
        len_d[ld_bank_q]     = eff_len;
        bank_st_d[ld_bank_q] = B_FILLING;
      end
      if (wr_last) begin
        wr_cnt_d             = '0;
        bank_st_d[ld_bank_q] = B_FULL;
        ld_bank_d            = ~ld_bank_q;
      end
    end

    if (issue) begin
      bank_st_d[ex_bank_q] = B_DRAINING;
      rd_cnt_d             = rd_last ? '0 : rd_cnt_q + AW'(1);
      ex_st_d              = rd_last ? EX_FLUSH : EX_STREAM;
    end else if (ex_st_q == EX_IDLE && bank_st_q[ex_bank_q] == B_FULL) begin
      ex_st_d = EX_STREAM;
    end
    if (ex_st_q == EX_FLUSH && pop && ex_last_q) begin
      bank_st_d[ex_bank_q] = B_EMPTY;
      ex_bank_d            = ~ex_bank_q;
      ex_st_d              = EX_IDLE;
    end

    inflight_d      = issue;
    inflight_last_d = issue & rd_last;

    if (slot_free) begin
      if (skid_vld_q) begin
        ex_valid_d  = 1'b1;
        ex_data_d   = skid_data_q;
        ex_last_d   = skid_last_q;
        skid_vld_d  = inflight_q;
        skid_data_d = inflight_q ? bus.mem_rd_data : skid_data_q;
        skid_last_d = inflight_q & inflight_last_q;
      end else begin
        ex_valid_d = inflight_q;
        ex_data_d  = inflight_q ? bus.mem_rd_data : ex_data_q;
        ex_last_d  = inflight_q & inflight_last_q;
      end
    end else if (inflight_q) begin
      skid_vld_d  = 1'b1;
      skid_data_d = bus.mem_rd_data;
      skid_last_d = inflight_last_q;
    end

    nxt_ld_st  = bank_st_d[ld_bank_d];
    ld_ready_d = (nxt_ld_st == B_EMPTY) || (nxt_ld_st == B_FILLING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st_q[0]    <= B_EMPTY;
      bank_st_q[1]    <= B_EMPTY;
      len_q[0]        <= '0;
      len_q[1]        <= '0;
      ld_bank_q       <= 1'b0;
      ex_bank_q       <= 1'b0;
      wr_cnt_q        <= '0;
      rd_cnt_q        <= '0;
      ex_st_q         <= EX_IDLE;
      ld_ready_q      <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      ex_valid_q      <= 1'b0;
      ex_last_q       <= 1'b0;
      ex_data_q       <= '0;
      skid_vld_q      <= 1'b0;
      skid_last_q     <= 1'b0;
      skid_data_q     <= '0;
    end else begin
      bank_st_q       <= bank_st_d;
      len_q           <= len_d;
      ld_bank_q       <= ld_bank_d;
      ex_bank_q       <= ex_bank_d;
      wr_cnt_q        <= wr_cnt_d;
      rd_cnt_q        <= rd_cnt_d;
      ex_st_q         <= ex_st_d;
      ld_ready_q      <= ld_ready_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      ex_valid_q      <= ex_valid_d;
      ex_last_q       <= ex_last_d;
      ex_data_q       <= ex_data_d;
      skid_vld_q      <= skid_vld_d;
      skid_last_q     <= skid_last_d;
      skid_data_q     <= skid_data_d;
    end
  end

  assign bus.ld_ready     = ld_ready_q;
  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_data      = ex_data_q;
  assign bus.ex_last      = ex_last_q;
  assign bus.mem_wr_en    = hs;
  assign bus.mem_wr_addr  = hs ? {ld_bank_q, wr_cnt_q} : '0;
  assign bus.mem_wr_data  = hs ? bus.ld_data : '0;
  assign bus.mem_rd_addr  = {ex_bank_q, rd_cnt_q};
  assign bus.bank_full[0] = (bank_st_q[0] == B_FULL) || (bank_st_q[0] == B_DRAINING);
  assign bus.bank_full[1] = (bank_st_q[1] == B_FULL) || (bank_st_q[1] == B_DRAINING);
endmodule

// File: tb/tb_bram_pingpong_ctrl.sv
// Directed bench for bram_pingpong_ctrl with a behavioural 1-cycle-latency BRAM.
module tb_bram_pingpong_ctrl;
  localparam int AW = 8;
  localparam int DW = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  bram_pingpong_if #(.AW(AW), .DW(DW)) bus ();
  bram_pingpong_ctrl #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [DW-1:0] mem [0:(2**(AW+1))-1];
  always @(posedge clk) begin
    if (bus.mem_wr_en) mem[bus.mem_wr_addr] <= bus.mem_wr_data;
    bus.mem_rd_data <= mem[bus.mem_rd_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] got_d [$];
  logic          got_l [$];
  int            got_c [$];
  logic [AW:0]   wa_q  [$];
  logic [DW-1:0] wd_q  [$];
  int            stall_seen = 0;
  int            stall_viol = 0;
  logic          stall_p = 1'b0;
  logic [DW-1:0] stall_d;
  logic          stall_l;

  // Handshakes happen at the next posedge with the values seen here.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_p) begin
        stall_seen++;
        if (!(bus.ex_valid === 1'b1 && bus.ex_data === stall_d && bus.ex_last === stall_l))
          stall_viol++;
      end
      if (bus.ex_valid && bus.ex_ready) begin
        got_d.push_back(bus.ex_data);
        got_l.push_back(bus.ex_last);
        got_c.push_back(cyc);
      end
      if (bus.mem_wr_en) begin
        wa_q.push_back(bus.mem_wr_addr);
        wd_q.push_back(bus.mem_wr_data);
      end
      stall_p = bus.ex_valid & ~bus.ex_ready;
      stall_d = bus.ex_data;
      stall_l = bus.ex_last;
    end else begin
      stall_p = 1'b0;
    end
  end

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    got_d.delete(); got_l.delete(); got_c.delete(); wa_q.delete(); wd_q.delete();
  endtask

  task automatic chk_all_zero(string tg);
    chk({tg, "_ld_ready"},  bus.ld_ready, 0);
    chk({tg, "_ex_valid"},  bus.ex_valid, 0);
    chk({tg, "_ex_data"},   bus.ex_data, 0);
    chk({tg, "_ex_last"},   bus.ex_last, 0);
    chk({tg, "_wr_en"},     bus.mem_wr_en, 0);
    chk({tg, "_wr_addr"},   bus.mem_wr_addr, 0);
    chk({tg, "_wr_data"},   bus.mem_wr_data, 0);
    chk({tg, "_rd_addr"},   bus.mem_rd_addr, 0);
    chk({tg, "_bank_full"}, bus.bank_full, 0);
  endtask

  task automatic send_beat(logic [DW-1:0] d, output int waited);
    int w = 0;
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    while (!bus.ld_ready && w < 50) begin tick(); w++; end
    if (!bus.ld_ready) chk("ld_ready_timeout", bus.ld_ready, 1);
    waited = w;
    tick();
    bus.ld_valid = 1'b0;
  endtask

  task automatic drain(string tag, int n, int budget);
    int w = 0;
    while (got_d.size() < n && w < budget) begin tick(); w++; end
    chk(tag, got_d.size(), n);
  endtask

  task automatic do_reset();
    bus.ld_valid = 1'b0;
    bus.ex_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    clear_logs();
  endtask

  initial begin
    logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int w, k, gap;
    bus.cfg_len  = 4;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.ex_ready = 1'b0;

    // Reset state, with a load beat offered to show the write port stays quiet.
    #2 rst_n = 1'b0;
    bus.ld_valid = 1'b1; bus.ld_data = 'hFF;
    #1 chk_all_zero("rst");
    tick(); tick();
    bus.ld_valid = 1'b0;
    rst_n = 1'b1;
    #1 chk("rst_rel_ld_ready0", bus.ld_ready, 0);
    tick();
    chk("rst_rel_ld_ready1", bus.ld_ready, 1);

    // Single tile of 4, exact cycle timing.
    bus.cfg_len = 4; bus.ex_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid = 1'b1; bus.ld_data = 'hA0 + i;
      #1;
      chk("t1_ld_ready", bus.ld_ready, 1);
      chk("t1_wr_en", bus.mem_wr_en, 1);
      chk("t1_wr_addr", bus.mem_wr_addr, i);
      chk("t1_wr_data", bus.mem_wr_data, 'hA0 + i);
      tick();
    end
    bus.ld_valid = 1'b0;
    #1;
    chk("t1_wr_en_idle", bus.mem_wr_en, 0);
    chk("t1_bank_full_E", bus.bank_full, 2'b01);
    chk("t1_ex_valid_E", bus.ex_valid, 0);
    chk("t1_rd_addr_E", bus.mem_rd_addr, 0);
    tick();
    chk("t1_ex_valid_E1", bus.ex_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_ex_valid", bus.ex_valid, 1);
      chk("t1_ex_data", bus.ex_data, 'hA0 + i);
      chk("t1_ex_last", bus.ex_last, (i == 3));
    end
    tick();
    chk("t1_ex_valid_end", bus.ex_valid, 0);
    chk("t1_bank_full_end", bus.bank_full, 2'b00);
    clear_logs();

    // Reset mid-stream, then ping-pong of two 8-word tiles.
    bus.cfg_len = 4;
    send_beat('hB0, w);
    send_beat('hB1, w);
    bus.ld_valid = 1'b1; bus.ld_data = 'hB2;
    rst_n = 1'b0;
    #1 chk_all_zero("rst_mid");
    bus.ld_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    #1 chk("rst_mid_ld_ready0", bus.ld_ready, 0);
    tick();
    chk("rst_mid_ld_ready1", bus.ld_ready, 1);
    clear_logs();

    bus.cfg_len = 8; bus.ex_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send_beat((i < 8) ? i : 'h10 + i - 8, w);
      chk("t2_no_ld_stall", w, 0);
    end
    drain("t2_count", 16, 100);
    for (int i = 0; i < 16 && i < got_d.size(); i++) begin
      chk("t2_wr_addr", wa_q[i], (i < 8) ? i : 'h100 + i - 8);
      chk("t2_data", got_d[i], (i < 8) ? i : 'h10 + i - 8);
      chk("t2_last", got_l[i], (i == 7 || i == 15));
      if (i > 0) begin
        gap = got_c[i] - got_c[i-1];
        if (i == 8) chk("t2_turn_gap_le3", (gap <= 3), 1);
        else        chk("t2_gap_1", gap, 1);
      end
    end
    clear_logs();

    // Backpressure on a 16-word tile.
    bus.cfg_len = 16; bus.ex_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send_beat('h30 + i, w);
      chk("t3_no_ld_stall", w, 0);
    end
    for (int c = 0; c < 300 && got_d.size() < 16; c++) begin
      bus.ex_ready = pat[c % 6];
      tick();
    end
    chk("t3_count", got_d.size(), 16);
    for (int i = 0; i < 16 && i < got_d.size(); i++) begin
      chk("t3_data", got_d[i], 'h30 + i);
      chk("t3_last", got_l[i], (i == 15));
    end
    chk("t3_stalls_seen", (stall_seen > 0), 1);
    chk("t3_stall_hold", stall_viol, 0);
    bus.ex_ready = 1'b1;
    tick(); tick();

    // Both banks full, third tile waits for bank 0 to drain.
    do_reset();
    bus.cfg_len = 4; bus.ex_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_beat((i < 4) ? 'h20 + i : 'h30 + i - 4, w);
      chk("t4_no_ld_stall", w, 0);
    end
    bus.ld_valid = 1'b1; bus.ld_data = 'h40;
    #1;
    chk("t4_ld_ready0", bus.ld_ready, 0);
    chk("t4_bank_full11", bus.bank_full, 2'b11);
    chk("t4_no_write", bus.mem_wr_en, 0);
    tick();
    chk("t4_ld_ready_hold0", bus.ld_ready, 0);
    bus.ex_ready = 1'b1;
    k = -1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.ld_ready) begin k = cyc; break; end
    end
    chk("t4_got_bank0", (got_d.size() >= 4), 1);
    if (got_c.size() >= 4) chk("t4_ready_after_last", k, got_c[3] + 1);
    tick();
    bus.ld_valid = 1'b0;
    for (int i = 1; i < 4; i++) send_beat('h40 + i, w);
    drain("t4_count", 12, 100);
    for (int i = 0; i < 12 && i < got_d.size(); i++) begin
      chk("t4_data", got_d[i], (i < 4) ? 'h20 + i : (i < 8) ? 'h30 + i - 4 : 'h40 + i - 8);
      chk("t4_last", got_l[i], (i == 3 || i == 7 || i == 11));
    end
    chk("t4_tileC_addr", wa_q.size() > 8 ? wa_q[8] : '1, 0);
    chk("t4_stall_hold", stall_viol, 0);

    // Boundaries: cfg_len=0 acts as 1; cfg_len=256 fills a whole bank.
    do_reset();
    bus.ex_ready = 1'b1; bus.cfg_len = 0;
    send_beat('h55, w);
    drain("t5_len0_count", 1, 20);
    if (got_d.size() >= 1) begin
      chk("t5_len0_data", got_d[0], 'h55);
      chk("t5_len0_last", got_l[0], 1);
      chk("t5_len0_addr", wa_q[0], 0);
    end
    tick(); tick();
    chk("t5_len0_bank_full", bus.bank_full, 0);
    clear_logs();
    bus.cfg_len = 9'h100;
    for (int i = 0; i < 256; i++) send_beat('h1000 + i, w);
    drain("t5_len256_count", 256, 400);
    chk("t5_len256_writes", wa_q.size(), 256);
    for (int i = 0; i < 256 && i < got_d.size() && i < wa_q.size(); i++) begin
      chk("t5_len256_addr", wa_q[i], 'h100 + i);
      chk("t5_len256_data", got_d[i], 'h1000 + i);
      chk("t5_len256_last", got_l[i], (i == 255));
    end
    tick(); tick();
    chk("t5_len256_bank_full", bus.bank_full, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
